// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the fetch stage
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register with hold and bubble insertion
module if_id_register (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);
  import cpu_pkg::*;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  // A held register must keep the stalled instruction, so hold beats flush.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (we_i) begin
      if (flush_i) begin
        instr_d = NOP_INSTR;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
      end else begin
        instr_d = instr_i;
        pc4_d   = pc4_i;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, next-PC mux, start FSM and stall counter
module fetch_stage #(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   PCWrite_i,
  input  logic                   IF_IDWrite_i,
  input  logic                   Flush_i,
  input  logic                   Jump_i,
  input  logic [31:0]            BranchAddr_i,
  input  logic [31:0]            JumpAddr_i,
  input  logic [31:0]            instr_i,
  output logic [31:0]            pc_o,
  output logic [31:0]            IF_ID_pc4_o,
  output logic [31:0]            IF_ID_instr_o,
  output logic                   IF_ID_valid_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  import cpu_pkg::*;

  fetch_state_e           state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [31:0]            pc_plus4;
  logic                   if_id_we;

  assign pc_plus4 = pc_q + PC_STEP;
  assign if_id_we = (state_q == RUN) && IF_IDWrite_i;

  // A stalled PC ignores redirects: the redirecting instruction is still in ID.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      IDLE: begin
        pc_d = PC_RESET;
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (PCWrite_i) begin
          if (Jump_i)       pc_d = JumpAddr_i;
          else if (Flush_i) pc_d = BranchAddr_i;
          else              pc_d = pc_plus4;
        end else if (stall_cnt_q != '1) begin
          stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pc_q        <= PC_RESET;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  if_id_register u_if_id (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (if_id_we),
    .flush_i (Flush_i | Jump_i),
    .instr_i (instr_i),
    .pc4_i   (pc_plus4),
    .instr_o (IF_ID_instr_o),
    .pc4_o   (IF_ID_pc4_o),
    .valid_o (IF_ID_valid_o)
  );

  assign pc_o        = pc_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, PCWrite_i, IF_IDWrite_i, Flush_i, Jump_i;
  logic [31:0] BranchAddr_i, JumpAddr_i, instr_i;
  logic [31:0] pc_o, IF_ID_pc4_o, IF_ID_instr_o;
  logic        IF_ID_valid_o;
  logic [15:0] stall_cnt_o;
  logic [31:0] pc4_o_n, ifid_pc4_4, ifid_instr_4;
  logic        ifid_valid_4;
  logic [3:0]  stall_cnt_4;

  int compared = 0;
  int mismatched = 0;

  always #5 clk_i = ~clk_i;

  // Instruction memory: word at addr reads back as addr | 0xA000.
  assign instr_i = pc_o | 32'h0000_A000;

  fetch_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .PCWrite_i(PCWrite_i),
    .IF_IDWrite_i(IF_IDWrite_i), .Flush_i(Flush_i), .Jump_i(Jump_i),
    .BranchAddr_i(BranchAddr_i), .JumpAddr_i(JumpAddr_i), .instr_i(instr_i),
    .pc_o(pc_o), .IF_ID_pc4_o(IF_ID_pc4_o), .IF_ID_instr_o(IF_ID_instr_o),
    .IF_ID_valid_o(IF_ID_valid_o), .stall_cnt_o(stall_cnt_o)
  );

  fetch_stage #(.STALL_CNT_W(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .PCWrite_i(PCWrite_i),
    .IF_IDWrite_i(IF_IDWrite_i), .Flush_i(Flush_i), .Jump_i(Jump_i),
    .BranchAddr_i(BranchAddr_i), .JumpAddr_i(JumpAddr_i), .instr_i(instr_i),
    .pc_o(pc4_o_n), .IF_ID_pc4_o(ifid_pc4_4), .IF_ID_instr_o(ifid_instr_4),
    .IF_ID_valid_o(ifid_valid_4), .stall_cnt_o(stall_cnt_4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                            input logic valid);
    check({tag, "_instr"}, IF_ID_instr_o, instr);
    check({tag, "_pc4"}, IF_ID_pc4_o, pc4);
    check({tag, "_valid"}, {31'h0, IF_ID_valid_o}, {31'h0, valid});
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; PCWrite_i = 1'b1; IF_IDWrite_i = 1'b1;
    Flush_i = 1'b0; Jump_i = 1'b0; BranchAddr_i = 32'h0; JumpAddr_i = 32'h0;
    tick(2);
    check("rst_pc", pc_o, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst_cnt", {16'h0, stall_cnt_o}, 32'h0);

    // Idle with no start: nothing moves.
    rst_i = 1'b0;
    tick(2);
    check("idle_pc", pc_o, 32'h0);
    check("idle_valid", {31'h0, IF_ID_valid_o}, 32'h0);

    start_i = 1'b1;
    tick(1);
    check("start_pc", pc_o, 32'h0);
    check("start_valid", {31'h0, IF_ID_valid_o}, 32'h0);
    start_i = 1'b0;
    tick(1);
    check("run1_pc", pc_o, 32'h4);
    check_ifid("run1", 32'h0000_A000, 32'h4, 1'b1);
    tick(1);
    check("run2_pc", pc_o, 32'h8);
    check_ifid("run2", 32'h0000_A004, 32'h8, 1'b1);
    tick(2);
    check("run4_pc", pc_o, 32'h10);
    check_ifid("run4", 32'h0000_A00C, 32'h10, 1'b1);

    // Two-cycle load-use stall.
    PCWrite_i = 1'b0; IF_IDWrite_i = 1'b0;
    tick(1);
    check("stall1_pc", pc_o, 32'h10);
    check("stall1_cnt", {16'h0, stall_cnt_o}, 32'd1);
    tick(1);
    check("stall2_pc", pc_o, 32'h10);
    check_ifid("stall2", 32'h0000_A00C, 32'h10, 1'b1);
    check("stall2_cnt", {16'h0, stall_cnt_o}, 32'd2);
    PCWrite_i = 1'b1; IF_IDWrite_i = 1'b1;
    tick(1);
    check("rel_pc", pc_o, 32'h14);
    check_ifid("rel", 32'h0000_A010, 32'h14, 1'b1);

    // Branch redirect with one bubble.
    Flush_i = 1'b1; BranchAddr_i = 32'h40;
    tick(1);
    check("br_pc", pc_o, 32'h40);
    check_ifid("br", 32'h0, 32'h0, 1'b0);
    Flush_i = 1'b0;
    tick(1);
    check("br_next_pc", pc_o, 32'h44);
    check_ifid("br_next", 32'h0000_A040, 32'h44, 1'b1);

    // Jump beats branch.
    Flush_i = 1'b1; Jump_i = 1'b1; JumpAddr_i = 32'h80;
    tick(1);
    check("jmp_pc", pc_o, 32'h80);
    check("jmp_valid", {31'h0, IF_ID_valid_o}, 32'h0);
    Flush_i = 1'b0; Jump_i = 1'b0;
    tick(1);
    check("jmp_next_pc", pc_o, 32'h84);
    check_ifid("jmp_next", 32'h0000_A080, 32'h84, 1'b1);

    // Redirect during stall is ignored.
    Flush_i = 1'b1; Jump_i = 1'b1; PCWrite_i = 1'b0; IF_IDWrite_i = 1'b0;
    tick(1);
    check("stfl_pc", pc_o, 32'h84);
    check_ifid("stfl", 32'h0000_A080, 32'h84, 1'b1);
    check("stfl_cnt", {16'h0, stall_cnt_o}, 32'd3);
    Flush_i = 1'b0; PCWrite_i = 1'b1; IF_IDWrite_i = 1'b1;

    // PC wrap at the top of the address space.
    JumpAddr_i = 32'hFFFF_FFFC;
    tick(1);
    check("wrap_jmp_pc", pc_o, 32'hFFFF_FFFC);
    Jump_i = 1'b0;
    tick(1);
    check("wrap_pc", pc_o, 32'h0);
    check_ifid("wrap", 32'hFFFF_FFFC, 32'h0, 1'b1);

    // Counter saturation on the 4-bit instance; 16-bit keeps counting.
    PCWrite_i = 1'b0; IF_IDWrite_i = 1'b0;
    tick(12);
    check("sat12_cnt4", {28'h0, stall_cnt_4}, 32'd15);
    check("sat12_cnt16", {16'h0, stall_cnt_o}, 32'd15);
    tick(8);
    check("sat20_cnt4", {28'h0, stall_cnt_4}, 32'd15);
    check("sat20_cnt16", {16'h0, stall_cnt_o}, 32'd23);
    check("sat20_pc", pc_o, 32'h0);

    // Reset while stalled and redirecting.
    Flush_i = 1'b1; Jump_i = 1'b1; rst_i = 1'b1;
    tick(1);
    check("mrst_pc", pc_o, 32'h0);
    check_ifid("mrst", 32'h0, 32'h0, 1'b0);
    check("mrst_cnt", {16'h0, stall_cnt_o}, 32'h0);
    check("mrst_cnt4", {28'h0, stall_cnt_4}, 32'h0);
    rst_i = 1'b0; Flush_i = 1'b0; Jump_i = 1'b0; PCWrite_i = 1'b1; IF_IDWrite_i = 1'b1;
    tick(5);
    check("post_idle_pc", pc_o, 32'h0);
    check("post_idle_pc4", pc4_o_n, 32'h0);
    check_ifid("post_idle", 32'h0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
